// File: rtl/stopwatch_ctrl.sv
// Stopwatch / countdown controller feeding the 4-digit 7-segment driver.
// Digits are BCD SS.hh; curr_val0 is the leftmost (seconds tens) digit.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] curr_val0,
  output logic [3:0] curr_val1,
  output logic [3:0] curr_val2,
  output logic [3:0] curr_val3,
  output logic [2:0] currModeControl,
  output logic       done
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    SET   = 3'd4,
    CDOWN = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     count_q, count_d;
  logic [15:0]     lap_q, lap_d;
  logic [7:0]      preset_q, preset_d;
  logic            tick;
  logic            go_start, go_lap, go_mode, go_inc;
  logic [15:0]     disp;

  // Ripple BCD increment over four digits; any digit >= 9 rolls to 0 with carry.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] sec_inc(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    if (r[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (r[7:4] >= 4'd9) ? 4'd0 : r[7:4] + 4'd1;
    end else begin
      r[3:0] = r[3:0] + 4'd1;
    end
    return r;
  endfunction

  assign tick     = (presc_q == PMAX);
  assign go_start = btn_start;
  assign go_lap   = btn_lap & ~btn_start;
  assign go_mode  = btn_mode & ~btn_start & ~btn_lap;
  assign go_inc   = btn_inc & ~btn_start & ~btn_lap & ~btn_mode;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    lap_d    = lap_q;
    preset_d = preset_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);

    // Count update is decided by the pre-edge state; transitions may override it below.
    unique case (state_q)
      RUN, LAP:   if (tick) count_d = bcd_inc(count_q);
      CDOWN:      if (tick && count_q != 16'h0000) count_d = bcd_dec(count_q);
      IDLE, DONE: count_d = 16'h0000;
      default:    ;
    endcase

    case (state_q)
      IDLE: begin
        if (go_start)     state_d = RUN;
        else if (go_mode) state_d = SET;
      end
      RUN: begin
        if (go_start) begin
          state_d = PAUSE;
        end else if (go_lap) begin
          state_d = LAP;
          lap_d   = count_d;
        end
      end
      PAUSE: begin
        if (go_start) begin
          state_d = RUN;
        end else if (go_lap) begin
          state_d = IDLE;
          count_d = 16'h0000;
        end
      end
      LAP: begin
        if (go_start)    state_d = PAUSE;
        else if (go_lap) state_d = RUN;
      end
      SET: begin
        if (go_start) begin
          if (preset_q != 8'h00) begin
            state_d = CDOWN;
            count_d = {preset_q, 8'h00};
          end
        end else if (go_mode) begin
          state_d = IDLE;
        end else if (go_inc) begin
          preset_d = sec_inc(preset_q);
        end
      end
      CDOWN: begin
        if (go_lap) begin
          state_d = SET;
          count_d = 16'h0000;
        end else if (tick && count_q == 16'h0001) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (go_start || go_lap || go_mode) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      count_q  <= 16'h0000;
      lap_q    <= 16'h0000;
      preset_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      lap_q    <= lap_d;
      preset_q <= preset_d;
    end
  end

  always_comb begin
    disp = count_q;
    if (state_q == LAP)      disp = lap_q;
    else if (state_q == SET) disp = {preset_q, 8'h00};
  end

  assign {curr_val0, curr_val1, curr_val2, curr_val3} = disp;
  assign currModeControl = state_q;
  assign done            = (state_q == DONE);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scenario bench for stopwatch_ctrl with TICK_DIV=4 (one tick every 4 clocks).
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic btn_start = 1'b0, btn_lap = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
  logic [3:0] cv0, cv1, cv2, cv3;
  logic [2:0] mode;
  logic       done;

  int checks = 0;
  int errors = 0;
  int unsigned ecnt = 0;
  logic [19:0] sb[$];
  logic [19:0] exp_v;

  always #5 clk = ~clk;

  // Edges since reset release; the next edge carries a tick when ecnt%4 == 3.
  always @(posedge clk) begin
    if (!nRst) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .nRst(nRst),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .curr_val0(cv0), .curr_val1(cv1), .curr_val2(cv2), .curr_val3(cv3),
    .currModeControl(mode), .done(done)
  );

  function automatic logic [19:0] obs();
    return {cv0, cv1, cv2, cv3, mode, done};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic s, input logic l, input logic m, input logic i);
    btn_start = s; btn_lap = l; btn_mode = m; btn_inc = i;
    @(negedge clk);
    btn_start = 1'b0; btn_lap = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic align(input int unsigned p);
    int n = 0;
    while ((ecnt % 4) != p && n < 8) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    btn_start = 1'b1;
    idle(2);
    btn_start = 1'b0;
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL reset: got=%h exp=%h", obs(), exp_v); end
    nRst = 1'b1;
  endtask

  task automatic test_run_pause_clear();
    press(1, 0, 0, 0);
    sb.push_back({4'd0, 4'd1, 4'd0, 4'd0, 3'd1, 1'b0});
    idle(400);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL run_1s: got=%h exp=%h", obs(), exp_v); end
    press(1, 0, 0, 0);
    sb.push_back({4'd0, 4'd1, 4'd0, 4'd0, 3'd2, 1'b0});
    sb.push_back({4'd0, 4'd1, 4'd0, 4'd0, 3'd2, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL pause: got=%h exp=%h", obs(), exp_v); end
    idle(44);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL pause_hold: got=%h exp=%h", obs(), exp_v); end
    press(0, 1, 0, 0);
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL clear: got=%h exp=%h", obs(), exp_v); end
  endtask

  task automatic test_wrap();
    logic bad = 1'b0;
    align(0);
    press(1, 0, 0, 0);
    sb.push_back({4'd9, 4'd9, 4'd9, 4'd8, 3'd1, 1'b0});
    sb.push_back({4'd9, 4'd9, 4'd9, 4'd9, 3'd1, 1'b0});
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd1, 1'b0});
    repeat (39992) begin
      @(negedge clk);
      if (cv0 > 4'd9 || cv1 > 4'd9 || cv2 > 4'd9 || cv3 > 4'd9) bad = 1'b1;
    end
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL pre_9998: got=%h exp=%h", obs(), exp_v); end
    repeat (4) begin
      @(negedge clk);
      if (cv0 > 4'd9 || cv1 > 4'd9 || cv2 > 4'd9 || cv3 > 4'd9) bad = 1'b1;
    end
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL at_9999: got=%h exp=%h", obs(), exp_v); end
    repeat (4) begin
      @(negedge clk);
      if (cv0 > 4'd9 || cv1 > 4'd9 || cv2 > 4'd9 || cv3 > 4'd9) bad = 1'b1;
    end
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL wrap_0000: got=%h exp=%h", obs(), exp_v); end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL digit_range: got=%b exp=0", bad); end
  endtask

  task automatic test_lap();
    idle(200);
    press(0, 1, 0, 0);
    sb.push_back({4'd0, 4'd0, 4'd5, 4'd0, 3'd3, 1'b0});
    sb.push_back({4'd0, 4'd0, 4'd5, 4'd0, 3'd3, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL lap_enter: got=%h exp=%h", obs(), exp_v); end
    idle(40);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL lap_frozen: got=%h exp=%h", obs(), exp_v); end
    idle(39);
    press(0, 1, 0, 0);
    sb.push_back({4'd0, 4'd0, 4'd7, 4'd0, 3'd1, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL lap_leave: got=%h exp=%h", obs(), exp_v); end
  endtask

  task automatic test_priority();
    press(1, 1, 0, 0);
    sb.push_back({4'd0, 4'd0, 4'd7, 4'd0, 3'd2, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL start_over_lap: got=%h exp=%h", obs(), exp_v); end
    press(0, 0, 1, 1);
    sb.push_back({4'd0, 4'd0, 4'd7, 4'd0, 3'd2, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL pause_ignores: got=%h exp=%h", obs(), exp_v); end
    press(1, 0, 0, 0);
    align(3);
    press(1, 0, 0, 0);
    sb.push_back({4'd0, 4'd0, 4'd7, 4'd1, 3'd2, 1'b0});
    sb.push_back({4'd0, 4'd0, 4'd7, 4'd1, 3'd2, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL tick_and_start: got=%h exp=%h", obs(), exp_v); end
    idle(8);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL tick_start_hold: got=%h exp=%h", obs(), exp_v); end
    press(0, 1, 0, 0);
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL clear2: got=%h exp=%h", obs(), exp_v); end
  endtask

  task automatic test_countdown();
    press(0, 0, 1, 0);
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd4, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL set_enter: got=%h exp=%h", obs(), exp_v); end
    repeat (3) press(0, 0, 0, 1);
    sb.push_back({4'd0, 4'd3, 4'd0, 4'd0, 3'd4, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL preset_3: got=%h exp=%h", obs(), exp_v); end
    press(1, 0, 0, 0);
    sb.push_back({4'd0, 4'd3, 4'd0, 4'd0, 3'd5, 1'b0});
    sb.push_back({4'd0, 4'd1, 4'd5, 4'd0, 3'd5, 1'b0});
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd6, 1'b1});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL cdown_load: got=%h exp=%h", obs(), exp_v); end
    idle(600);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL cdown_mid: got=%h exp=%h", obs(), exp_v); end
    idle(600);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL cdown_done: got=%h exp=%h", obs(), exp_v); end
    press(0, 0, 0, 1);
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd6, 1'b1});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL done_ignores_inc: got=%h exp=%h", obs(), exp_v); end
    press(1, 0, 0, 0);
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL done_exit: got=%h exp=%h", obs(), exp_v); end
  endtask

  task automatic test_reset_midrun();
    press(0, 0, 1, 0);
    sb.push_back({4'd0, 4'd3, 4'd0, 4'd0, 3'd4, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL preset_kept: got=%h exp=%h", obs(), exp_v); end
    press(1, 0, 0, 0);
    sb.push_back({4'd0, 4'd1, 4'd3, 4'd7, 3'd5, 1'b0});
    idle(652);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL cdown_0137: got=%h exp=%h", obs(), exp_v); end
    nRst = 1'b0;
    btn_lap = 1'b1;
    @(negedge clk);
    nRst = 1'b1;
    btn_lap = 1'b0;
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd0, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL mid_reset: got=%h exp=%h", obs(), exp_v); end
    press(0, 0, 1, 0);
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd4, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL preset_cleared: got=%h exp=%h", obs(), exp_v); end
    press(1, 0, 0, 0);
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd4, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL start_zero_preset: got=%h exp=%h", obs(), exp_v); end
    repeat (99) press(0, 0, 0, 1);
    sb.push_back({4'd9, 4'd9, 4'd0, 4'd0, 3'd4, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL preset_99: got=%h exp=%h", obs(), exp_v); end
    press(0, 0, 0, 1);
    sb.push_back({4'd0, 4'd0, 4'd0, 4'd0, 3'd4, 1'b0});
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL preset_wrap: got=%h exp=%h", obs(), exp_v); end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_run_pause_clear();
    test_wrap();
    test_lap();
    test_priority();
    test_countdown();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
